// File: rtl/dpot_scheduler_if.sv
// Request/grant bus between the requesters and dpot_scheduler.
// Each requester owns one bit of req/req_ramp/grant/done and one byte of req_value.
interface dpot_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_value;
  logic [N_REQ-1:0]   req_ramp;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;

  modport master (output req, req_value, req_ramp, input grant, done);
  modport slave  (input req, req_value, req_ramp, output grant, done);
endinterface

// File: rtl/dpot_scheduler.sv
// Round-robin arbiter and write sequencer for a shared dpot SPI interface.
// Services direct writes or stepped ramps with a programmable dwell between steps.
module dpot_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  dpot_scheduler_if.slave    bus,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy,
  output logic [7:0]         current,
  output logic [7:0]         dpot_value,
  output logic               dpot_update,
  input  logic               dpot_ready
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DWELL = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t             state_r, state_next_s;
  logic               meta_r, rdy_sync_r;
  logic [IDX_W-1:0]   ptr_r, win_idx_s;
  logic               win_found_s;
  logic [N_REQ-1:0]   req_s, grant_r, done_r;
  logic [7:0]         win_value_s;
  logic               win_ramp_s;
  logic [7:0]         target_r, current_r, value_r, next_s, step_eff_s;
  logic               ramp_r, busy_r, update_r, up_s;
  logic [8:0]         diff_s;
  logic [DWELL_W-1:0] dwell_cnt_r;

  // Two-flop synchronizer for the SPI-domain ready; idles high so reset looks "ready"
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r     <= 1'b1;
      rdy_sync_r <= 1'b1;
    end else begin
      meta_r     <= dpot_ready;
      rdy_sync_r <= meta_r;
    end
  end

  // Round-robin search from the pointer; a requester whose done is still visible is masked
  always_comb begin
    req_s       = bus.req & ~done_r;
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      win_idx_s   = (!win_found_s && req_s[IDX_W'((int'(ptr_r) + k) % N_REQ)])
                    ? IDX_W'((int'(ptr_r) + k) % N_REQ) : win_idx_s;
      win_found_s = win_found_s | req_s[IDX_W'((int'(ptr_r) + k) % N_REQ)];
    end
  end

  // Winner's target value and mode
  always_comb begin
    win_value_s = 8'd0;
    win_ramp_s  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      win_value_s = (win_idx_s == IDX_W'(k)) ? bus.req_value[8*k +: 8] : win_value_s;
      win_ramp_s  = (win_idx_s == IDX_W'(k)) ? bus.req_ramp[k] : win_ramp_s;
    end
  end

  // Next wiper value: 9-bit distance keeps the ramp from wrapping past 0 or 255
  always_comb begin
    step_eff_s = (step == 8'd0) ? 8'd1 : step;
    up_s       = (target_r >= current_r);
    diff_s     = up_s ? ({1'b0, target_r} - {1'b0, current_r})
                      : ({1'b0, current_r} - {1'b0, target_r});
    if (!ramp_r || (diff_s <= {1'b0, step_eff_s})) begin
      next_s = target_r;
    end else if (up_s) begin
      next_s = current_r + step_eff_s;
    end else begin
      next_s = current_r - step_eff_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = (|req_s) ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_next_s = win_found_s ? ST_CALC : ST_IDLE;
      ST_CALC:  state_next_s = (ramp_r && (current_r == target_r)) ? ST_DONE : ST_WRITE;
      ST_WRITE: state_next_s = rdy_sync_r ? ST_WRITE : ST_WAIT;
      ST_WAIT: begin
        if (!rdy_sync_r) begin
          state_next_s = ST_WAIT;
        end else if (!ramp_r || (value_r == target_r)) begin
          state_next_s = ST_DONE;
        end else if (dwell == {DWELL_W{1'b0}}) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_DWELL;
        end
      end
      ST_DWELL: state_next_s = (dwell_cnt_r == {DWELL_W{1'b0}}) ? ST_CALC : ST_DWELL;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs; busy/grant fall in the cycle done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r       <= {IDX_W{1'b0}};
      target_r    <= 8'd0;
      ramp_r      <= 1'b0;
      grant_r     <= {N_REQ{1'b0}};
      done_r      <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
      update_r    <= 1'b0;
      current_r   <= 8'd0;
      value_r     <= 8'd0;
      dwell_cnt_r <= {DWELL_W{1'b0}};
    end else begin
      busy_r   <= (state_next_s != ST_IDLE);
      update_r <= (state_next_s == ST_WRITE);
      done_r   <= {N_REQ{1'b0}};
      if ((state_r == ST_GRANT) && win_found_s) begin
        target_r <= win_value_s;
        ramp_r   <= win_ramp_s;
        grant_r  <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        ptr_r    <= (win_idx_s == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : win_idx_s + IDX_W'(1);
      end
      if ((state_r == ST_CALC) && (state_next_s == ST_WRITE)) begin
        value_r <= next_s;
      end
      if ((state_r == ST_WAIT) && rdy_sync_r) begin
        current_r <= value_r;
      end
      if ((state_r == ST_WAIT) && (state_next_s == ST_DWELL)) begin
        dwell_cnt_r <= dwell - DWELL_W'(1);
      end else if (state_r == ST_DWELL) begin
        dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
      end
      if (state_r == ST_DONE) begin
        done_r  <= grant_r;
        grant_r <= {N_REQ{1'b0}};
      end
    end
  end

  assign bus.grant   = grant_r;
  assign bus.done    = done_r;
  assign busy        = busy_r;
  assign current     = current_r;
  assign dpot_value  = value_r;
  assign dpot_update = update_r;
endmodule

// File: tb/tb_dpot_scheduler.sv
// Bench for dpot_scheduler: SPI-clocked dpot model, event monitor and a
// transaction-level reference model of arbitration and ramp arithmetic.
module tb_dpot_scheduler;
  localparam int N_REQ   = 4;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               spi_clk = 1'b0;
  logic               rst;
  logic [7:0]         step;
  logic [DWELL_W-1:0] dwell;
  logic               busy;
  logic [7:0]         current;
  logic [7:0]         dpot_value;
  logic               dpot_update;
  logic               dpot_ready = 1'b1;

  dpot_scheduler_if #(.N_REQ(N_REQ)) bus ();

  dpot_scheduler #(.N_REQ(N_REQ), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .step(step), .dwell(dwell),
    .busy(busy), .current(current), .dpot_value(dpot_value),
    .dpot_update(dpot_update), .dpot_ready(dpot_ready)
  );

  always #5 clk = ~clk;
  always #18 spi_clk = ~spi_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // dpot model: samples update on an SPI edge, ready low 3 edges later, high after 8
  int frame_cnt = 0;
  int wr_q[$];
  always @(posedge spi_clk) begin
    if (frame_cnt == 0) begin
      if (dpot_update === 1'b1) begin
        frame_cnt <= 1;
        wr_q.push_back(int'(dpot_value));
      end
    end else if (frame_cnt == 8) begin
      frame_cnt  <= 0;
      dpot_ready <= 1'b1;
    end else begin
      frame_cnt <= frame_cnt + 1;
      if (frame_cnt == 3) dpot_ready <= 1'b0;
    end
  end

  function automatic int idx_of(input logic [N_REQ-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N_REQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Event monitor
  int cyc = 0;
  int upd_rise_q[$];
  int upd_fall_q[$];
  int grant_idx_q[$];
  int done_idx_q[$];
  int done_bad = 0;
  logic prev_upd = 1'b0;
  logic [N_REQ-1:0] prev_grant = '0;
  logic [N_REQ-1:0] prev_done = '0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dpot_update && !prev_upd) upd_rise_q.push_back(cyc);
    if (!dpot_update && prev_upd) upd_fall_q.push_back(cyc);
    if (bus.grant != '0 && prev_grant == '0) grant_idx_q.push_back(idx_of(bus.grant));
    if (bus.done != '0) begin
      done_idx_q.push_back(idx_of(bus.done));
      if (busy || bus.grant != '0 || $countones(bus.done) != 1 || prev_done != '0)
        done_bad <= done_bad + 1;
    end
    prev_upd   <= dpot_update;
    prev_grant <= bus.grant;
    prev_done  <= bus.done;
  end

  // Reference model state
  logic [7:0] val [N_REQ];
  bit         rmp [N_REQ];
  int m_cur = 0;
  int m_ptr = 0;
  int exp_wr[$];
  int exp_done[$];

  function automatic int model_pick(input logic [N_REQ-1:0] p);
    int w;
    w = -1;
    for (int k = N_REQ - 1; k >= 0; k--) if (p[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
    m_ptr = (w + 1) % N_REQ;
    return w;
  endfunction

  function automatic void model_service(input int i);
    int t, s, d;
    t = int'(val[i]);
    s = (step == 8'd0) ? 1 : int'(step);
    exp_done.push_back(i);
    if (!rmp[i]) begin
      m_cur = t;
      exp_wr.push_back(t);
    end else begin
      while (m_cur != t) begin
        d = (t > m_cur) ? t - m_cur : m_cur - t;
        if (d <= s) m_cur = t;
        else m_cur = (t > m_cur) ? m_cur + s : m_cur - s;
        exp_wr.push_back(m_cur);
      end
    end
  endfunction

  function automatic void model_batch(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] p;
    int w;
    p = mask;
    while (p != '0) begin
      w = model_pick(p);
      p[w] = 1'b0;
      model_service(w);
    end
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg();
    for (int k = 0; k < N_REQ; k++) begin
      bus.req_value[8*k +: 8] = val[k];
      bus.req_ramp[k]         = rmp[k];
    end
  endtask

  task automatic clear_logs();
    wr_q.delete(); upd_rise_q.delete(); upd_fall_q.delete();
    grant_idx_q.delete(); done_idx_q.delete(); exp_wr.delete(); exp_done.delete();
  endtask

  // Raise the masked requests, drop each one when its done is seen
  task automatic serve(input logic [N_REQ-1:0] mask, output bit to, output int lat, output int g2d);
    logic [N_REQ-1:0] pend;
    int n;
    pend = mask; n = 0; lat = -1; g2d = -1;
    @(negedge clk);
    bus.req = mask;
    while (pend != '0 && n < 20000) begin
      @(negedge clk);
      n++;
      if (lat < 0 && bus.grant != '0) lat = n;
      if (g2d < 0 && bus.done != '0) g2d = n - lat;
      pend    = pend & ~bus.done;
      bus.req = bus.req & ~bus.done;
    end
    to = (pend != '0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_batch(input string tag, input bit to);
    chk({tag, "/timeout"}, to, 0);
    chk({tag, "/n_writes"}, wr_q.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++)
      chk({tag, "/write"}, wr_q[k], exp_wr[k]);
    chk({tag, "/n_done"}, done_idx_q.size(), exp_done.size());
    for (int k = 0; k < exp_done.size() && k < done_idx_q.size(); k++)
      chk({tag, "/done_idx"}, done_idx_q[k], exp_done[k]);
    for (int k = 0; k < exp_done.size() && k < grant_idx_q.size(); k++)
      chk({tag, "/grant_idx"}, grant_idx_q[k], exp_done[k]);
    chk({tag, "/current"}, current, m_cur);
    chk({tag, "/done_shape"}, done_bad, 0);
    clear_logs();
  endtask

  initial begin
    bit to;
    int lat, g2d, mg, n;
    logic [N_REQ-1:0] mask;

    rst = 1'b1; bus.req = '0; bus.req_value = '0; bus.req_ramp = '0;
    step = 8'd0; dwell = '0;
    for (int k = 0; k < N_REQ; k++) begin val[k] = 8'd0; rmp[k] = 1'b0; end
    #3 rst = 1'b0;
    #1 chk("reset_state", {bus.grant, bus.done, busy, dpot_update, current, dpot_value}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_not_busy", busy, 0);

    // Round-robin with all requests held continuously
    val[0] = 8'h11; val[1] = 8'h22; val[2] = 8'h33; val[3] = 8'h44;
    load_cfg();
    for (int k = 0; k < 5; k++) model_service(model_pick('1));
    bus.req = '1;
    n = 0;
    while (grant_idx_q.size() < 5 && n < 5000) begin @(negedge clk); n++; end
    bus.req = '0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check_batch("rr_held", n >= 5000);

    // Direct write
    val[0] = 8'h5A; rmp[0] = 1'b0; load_cfg();
    model_batch(4'b0001);
    serve(4'b0001, to, lat, g2d);
    chk("direct/grant_latency", lat, 2);
    chk("direct/dpot_value", dpot_value, 8'h5A);
    check_batch("direct", to);

    // Ramp up with dwell
    step = 8'd8; dwell = 16'd5;
    val[1] = 8'h10; rmp[1] = 1'b0; load_cfg();
    model_batch(4'b0010);
    serve(4'b0010, to, lat, g2d);
    check_batch("ramp_setup", to);
    val[2] = 8'h30; rmp[2] = 1'b1; load_cfg();
    model_batch(4'b0100);
    serve(4'b0100, to, lat, g2d);
    mg = 1000;
    for (int k = 0; k + 1 < upd_rise_q.size() && k < upd_fall_q.size(); k++)
      if (upd_rise_q[k+1] - upd_fall_q[k] < mg) mg = upd_rise_q[k+1] - upd_fall_q[k];
    chk("ramp_up/min_gap_ge_5", mg >= 5, 1);
    check_batch("ramp_up", to);

    // Clamp at top, then step 0 treated as 1 going down
    step = 8'd16; dwell = 16'd0;
    val[3] = 8'hFA; rmp[3] = 1'b0; val[0] = 8'hFF; rmp[0] = 1'b1; load_cfg();
    model_batch(4'b1000);
    serve(4'b1000, to, lat, g2d);
    check_batch("clamp_setup", to);
    model_batch(4'b0001);
    serve(4'b0001, to, lat, g2d);
    check_batch("clamp_top", to);
    step = 8'd0;
    val[1] = 8'h05; rmp[1] = 1'b0; val[2] = 8'h03; rmp[2] = 1'b1; load_cfg();
    model_batch(4'b0010);
    serve(4'b0010, to, lat, g2d);
    check_batch("step0_setup", to);
    model_batch(4'b0100);
    serve(4'b0100, to, lat, g2d);
    check_batch("step0_down", to);

    // Target equals current: ramp writes nothing, direct writes once
    val[3] = 8'h03; rmp[3] = 1'b1; load_cfg();
    model_batch(4'b1000);
    serve(4'b1000, to, lat, g2d);
    chk("equal_ramp/done_within_4", (g2d >= 0) && (g2d <= 4), 1);
    check_batch("equal_ramp", to);
    rmp[3] = 1'b0; load_cfg();
    model_batch(4'b1000);
    serve(4'b1000, to, lat, g2d);
    check_batch("equal_direct", to);

    // Randomized batches
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < N_REQ; k++) begin
        val[k] = 8'($urandom_range(0, 255));
        rmp[k] = 1'($urandom_range(0, 1));
      end
      step  = 8'($urandom_range(16, 80));
      dwell = DWELL_W'($urandom_range(0, 6));
      mask  = N_REQ'($urandom_range(1, 15));
      load_cfg();
      model_batch(mask);
      serve(mask, to, lat, g2d);
      check_batch("random", to);
    end

    // Reset while update is high
    val[1] = 8'h77; rmp[1] = 1'b0; load_cfg();
    @(negedge clk);
    bus.req = 4'b0010;
    n = 0;
    while (dpot_update !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid/update_seen", dpot_update, 1);
    rst = 1'b0;
    #1 chk("rst_mid/outputs", {bus.grant, bus.done, busy, dpot_update, current, dpot_value}, 0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("rst_mid/held", {bus.grant, bus.done, busy, dpot_update, current, dpot_value}, 0);
    rst = 1'b1;
    n = 0;
    while ((frame_cnt != 0 || dpot_ready !== 1'b1) && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("rst_mid/idle_after_release", busy, 0);
    clear_logs();
    m_cur = 0; m_ptr = 0;

    // Simultaneous requests from pointer 0, then a normal direct write
    val[1] = 8'h40; rmp[1] = 1'b0; val[3] = 8'h60; rmp[3] = 1'b0; load_cfg();
    model_batch(4'b1010);
    serve(4'b1010, to, lat, g2d);
    check_batch("simul_1010", to);
    val[2] = 8'h22; rmp[2] = 1'b0; load_cfg();
    model_batch(4'b0100);
    serve(4'b0100, to, lat, g2d);
    check_batch("after_reset_22", to);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
